// File: rtl/cpu_pkg.sv
// Shared opcode, operand-select and FSM encodings for the multi-cycle accumulator datapath.
package cpu_pkg;

    localparam logic [3:0] OP_NOP = 4'd0;
    localparam logic [3:0] OP_LD  = 4'd1;
    localparam logic [3:0] OP_ADD = 4'd2;
    localparam logic [3:0] OP_SUB = 4'd3;
    localparam logic [3:0] OP_AND = 4'd4;
    localparam logic [3:0] OP_OR  = 4'd5;
    localparam logic [3:0] OP_XOR = 4'd6;
    localparam logic [3:0] OP_NOT = 4'd7;
    localparam logic [3:0] OP_SHL = 4'd8;
    localparam logic [3:0] OP_SHR = 4'd9;
    localparam logic [3:0] OP_ADC = 4'd10;
    localparam logic [3:0] OP_SBB = 4'd11;
    localparam logic [3:0] OP_STR = 4'd12;
    localparam logic [3:0] OP_STM = 4'd13;
    localparam logic [3:0] OP_CMP = 4'd14;
    localparam logic [3:0] OP_CLC = 4'd15;

    // Any B select with the top bit set picks data memory.
    localparam logic [1:0] B_SEL_IMM = 2'b00;
    localparam logic [1:0] B_SEL_REG = 2'b01;
    localparam logic [1:0] B_SEL_MEM = 2'b10;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_READ = 2'd1;
    localparam logic [1:0] S_EXEC = 2'd2;

endpackage

// File: rtl/cpu_data_mc_if.sv
// Command/status bundle between the instruction decoder (master) and the datapath (slave).
interface cpu_data_mc_if #(
    parameter int WIDTH          = 8,
    parameter int REG_F_SEL_SIZE = 3,
    parameter int IN_B_SEL_SIZE  = 2,
    parameter int OP_SIZE        = 4
);
    logic                      START;
    logic [OP_SIZE-1:0]        OP;
    logic [IN_B_SEL_SIZE-1:0]  IN_B_SEL;
    logic [WIDTH-1:0]          IMM;
    logic [REG_F_SEL_SIZE-1:0] REG_F_SEL;
    logic [WIDTH-1:0]          D_MEM_ADDR;
    logic                      D_MEM_ADDR_MODE;
    logic                      BUSY;
    logic                      DONE;
    logic [WIDTH-1:0]          ACC_OUT;
    logic                      FLAG_C;
    logic                      FLAG_Z;

    modport master (
        output START, OP, IN_B_SEL, IMM, REG_F_SEL, D_MEM_ADDR, D_MEM_ADDR_MODE,
        input  BUSY, DONE, ACC_OUT, FLAG_C, FLAG_Z
    );

    modport slave (
        input  START, OP, IN_B_SEL, IMM, REG_F_SEL, D_MEM_ADDR, D_MEM_ADDR_MODE,
        output BUSY, DONE, ACC_OUT, FLAG_C, FLAG_Z
    );
endinterface

// File: rtl/cpu_alu_f.sv
// Accumulator ALU: computes result and carry/zero plus which of ACC/C/Z the op may update.
// Latency: purely combinational.
// Backpressure: none; the sequencer decides when the write enables take effect.
module cpu_alu_f
    import cpu_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int OP_SIZE = 4
) (
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    input  logic               C_IN,
    input  logic [OP_SIZE-1:0] OP,
    output logic [WIDTH-1:0]   RESULT,
    output logic               C_OUT,
    output logic               Z_OUT,
    output logic               ACC_WE,
    output logic               C_WE,
    output logic               Z_WE
);
    logic [WIDTH:0] ext;

    always_comb begin
        ext    = '0;
        RESULT = A;
        C_OUT  = C_IN;
        ACC_WE = 1'b0;
        C_WE   = 1'b0;
        Z_WE   = 1'b0;
        case (OP)
            OP_LD:  begin RESULT = B;     ACC_WE = 1'b1; Z_WE = 1'b1; end
            OP_AND: begin RESULT = A & B; ACC_WE = 1'b1; Z_WE = 1'b1; end
            OP_OR:  begin RESULT = A | B; ACC_WE = 1'b1; Z_WE = 1'b1; end
            OP_XOR: begin RESULT = A ^ B; ACC_WE = 1'b1; Z_WE = 1'b1; end
            OP_NOT: begin RESULT = ~A;    ACC_WE = 1'b1; Z_WE = 1'b1; end
            OP_ADD, OP_ADC: begin
                ext = {1'b0, A} + {1'b0, B}
                    + {{WIDTH{1'b0}}, (OP == OP_ADC) & C_IN};
                RESULT = ext[WIDTH-1:0];
                C_OUT  = ext[WIDTH];
                ACC_WE = 1'b1; C_WE = 1'b1; Z_WE = 1'b1;
            end
            // Subtraction in WIDTH+1 bits: the extra top bit is the borrow.
            OP_SUB, OP_SBB, OP_CMP: begin
                ext = {1'b0, A} - {1'b0, B}
                    - {{WIDTH{1'b0}}, (OP == OP_SBB) & C_IN};
                RESULT = ext[WIDTH-1:0];
                C_OUT  = ext[WIDTH];
                ACC_WE = (OP != OP_CMP);
                C_WE   = 1'b1;
                Z_WE   = 1'b1;
            end
            OP_SHL: begin
                RESULT = {A[WIDTH-2:0], 1'b0};
                C_OUT  = A[WIDTH-1];
                ACC_WE = 1'b1; C_WE = 1'b1; Z_WE = 1'b1;
            end
            OP_SHR: begin
                RESULT = {1'b0, A[WIDTH-1:1]};
                C_OUT  = A[0];
                ACC_WE = 1'b1; C_WE = 1'b1; Z_WE = 1'b1;
            end
            OP_CLC: begin C_OUT = 1'b0; C_WE = 1'b1; end
            default: ;
        endcase
    end

    assign Z_OUT = (RESULT == '0);

endmodule

// File: rtl/cpu_data_mc.sv
// Multi-cycle accumulator datapath: register file, sync-read data memory, ALU, ACC and flags.
// Latency: fixed 3 cycles per command (IDLE accept, READ, EXEC); DONE pulses in EXEC.
// Backpressure: BUSY high in READ/EXEC; START seen while BUSY is dropped, never queued.
module cpu_data_mc
    import cpu_pkg::*;
#(
    parameter int WIDTH          = 8,
    parameter int REG_SIZE       = 8,
    parameter int REG_F_SEL_SIZE = 3,
    parameter int D_MEM_DEPTH    = 256,
    parameter int D_ADDR_SIZE    = 8,
    parameter int IN_B_SEL_SIZE  = 2,
    parameter int OP_SIZE        = 4
) (
    input  logic         CLK,
    input  logic         RST,
    cpu_data_mc_if.slave bus
);
    logic [1:0]                state_q;
    logic [1:0]                state_d;
    logic                      accept;
    logic                      exec;

    logic [OP_SIZE-1:0]        op_q;
    logic [IN_B_SEL_SIZE-1:0]  b_sel_q;
    logic [WIDTH-1:0]          imm_q;
    logic [REG_F_SEL_SIZE-1:0] reg_sel_q;
    logic [WIDTH-1:0]          d_addr_q;
    logic                      addr_mode_q;

    logic [WIDTH-1:0]          regs_q [REG_SIZE];
    logic [WIDTH-1:0]          mem    [D_MEM_DEPTH];
    logic [WIDTH-1:0]          mem_rd_q;
    logic [WIDTH-1:0]          reg_rd;
    logic [D_ADDR_SIZE-1:0]    mem_addr;

    logic [WIDTH-1:0]          acc_q;
    logic                      c_q;
    logic                      z_q;
    logic [WIDTH-1:0]          b_val;

    logic [WIDTH-1:0]          alu_result;
    logic                      alu_c;
    logic                      alu_z;
    logic                      alu_acc_we;
    logic                      alu_c_we;
    logic                      alu_z_we;

    assign accept = (state_q == S_IDLE) && bus.START;
    assign exec   = (state_q == S_EXEC);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.START) state_d = S_READ;
            S_READ:  state_d = S_EXEC;
            S_EXEC:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge CLK) begin
        if (accept) begin
            op_q        <= bus.OP;
            b_sel_q     <= bus.IN_B_SEL;
            imm_q       <= bus.IMM;
            reg_sel_q   <= bus.REG_F_SEL;
            d_addr_q    <= bus.D_MEM_ADDR;
            addr_mode_q <= bus.D_MEM_ADDR_MODE;
        end
    end

    // The same wrapped address serves the READ-cycle fetch and the EXEC-cycle store.
    assign reg_rd   = regs_q[reg_sel_q];
    assign mem_addr = addr_mode_q ? reg_rd[D_ADDR_SIZE-1:0] : d_addr_q[D_ADDR_SIZE-1:0];

    always_ff @(posedge CLK) begin
        if (state_q == S_READ)
            mem_rd_q <= mem[mem_addr];
        if (exec && !RST && op_q == OP_STM)
            mem[mem_addr] <= acc_q;
    end

    always_comb begin
        if (b_sel_q == IN_B_SEL_SIZE'(B_SEL_IMM))      b_val = imm_q;
        else if (b_sel_q == IN_B_SEL_SIZE'(B_SEL_REG)) b_val = reg_rd;
        else                                           b_val = mem_rd_q;
    end

    cpu_alu_f #(
        .WIDTH   (WIDTH),
        .OP_SIZE (OP_SIZE)
    ) u_alu (
        .A      (acc_q),
        .B      (b_val),
        .C_IN   (c_q),
        .OP     (op_q),
        .RESULT (alu_result),
        .C_OUT  (alu_c),
        .Z_OUT  (alu_z),
        .ACC_WE (alu_acc_we),
        .C_WE   (alu_c_we),
        .Z_WE   (alu_z_we)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            acc_q <= '0;
            c_q   <= 1'b0;
            z_q   <= 1'b0;
            for (int i = 0; i < REG_SIZE; i++)
                regs_q[i] <= '0;
        end else if (exec) begin
            if (alu_acc_we) acc_q <= alu_result;
            if (alu_c_we)   c_q   <= alu_c;
            if (alu_z_we)   z_q   <= alu_z;
            if (op_q == OP_STR) regs_q[reg_sel_q] <= acc_q;
        end
    end

    assign bus.BUSY    = (state_q != S_IDLE);
    assign bus.DONE    = exec;
    assign bus.ACC_OUT = acc_q;
    assign bus.FLAG_C  = c_q;
    assign bus.FLAG_Z  = z_q;

endmodule

// File: tb/tb_cpu_data_mc.sv
// Randomised plus directed bench for cpu_data_mc against an arithmetic reference model.
module tb_cpu_data_mc;
    import cpu_pkg::*;

    localparam int W     = 8;
    localparam int NREG  = 8;
    localparam int SELW  = 3;
    localparam int DEPTH = 16;
    localparam int DAW   = 4;
    localparam int M     = 1 << W;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    cpu_data_mc_if #(.WIDTH(W), .REG_F_SEL_SIZE(SELW), .IN_B_SEL_SIZE(2), .OP_SIZE(4)) bus ();

    cpu_data_mc #(
        .WIDTH(W), .REG_SIZE(NREG), .REG_F_SEL_SIZE(SELW), .D_MEM_DEPTH(DEPTH),
        .D_ADDR_SIZE(DAW), .IN_B_SEL_SIZE(2), .OP_SIZE(4)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    int m_acc, m_c, m_z;
    int m_reg [NREG];
    int m_mem [DEPTH];

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_acc = 0; m_c = 0; m_z = 0;
        for (int i = 0; i < NREG; i++) m_reg[i] = 0;
    endtask

    task automatic model_exec(input int op, input int bsel, input int imm, input int sel,
                              input int daddr, input int mode);
        int addr, b, s;
        addr = (mode != 0 ? m_reg[sel] : daddr) % DEPTH;
        b    = (bsel == 0) ? imm : (bsel == 1) ? m_reg[sel] : m_mem[addr];
        case (op)
            1:  begin m_acc = b; m_z = (m_acc == 0); end
            2:  begin s = m_acc + b; m_c = (s >= M); m_acc = s % M; m_z = (m_acc == 0); end
            3:  begin m_c = (m_acc < b); m_acc = (m_acc - b + M) % M; m_z = (m_acc == 0); end
            4:  begin m_acc = m_acc & b; m_z = (m_acc == 0); end
            5:  begin m_acc = m_acc | b; m_z = (m_acc == 0); end
            6:  begin m_acc = m_acc ^ b; m_z = (m_acc == 0); end
            7:  begin m_acc = (M - 1) - m_acc; m_z = (m_acc == 0); end
            8:  begin m_c = (m_acc >= M / 2); m_acc = (m_acc * 2) % M; m_z = (m_acc == 0); end
            9:  begin m_c = m_acc % 2; m_acc = m_acc / 2; m_z = (m_acc == 0); end
            10: begin s = m_acc + b + m_c; m_c = (s >= M); m_acc = s % M; m_z = (m_acc == 0); end
            11: begin
                s = m_acc - b - m_c;
                m_c = (s < 0); m_acc = (s + 2 * M) % M; m_z = (m_acc == 0);
            end
            12: m_reg[sel] = m_acc;
            13: m_mem[addr] = m_acc;
            14: begin m_c = (m_acc < b); m_z = (m_acc == b); end
            15: m_c = 0;
            default: ;
        endcase
    endtask

    task automatic drive(input int op, input int bsel, input int imm, input int sel,
                         input int daddr, input int mode);
        bus.OP              = op[3:0];
        bus.IN_B_SEL        = bsel[1:0];
        bus.IMM             = imm[W-1:0];
        bus.REG_F_SEL       = sel[SELW-1:0];
        bus.D_MEM_ADDR      = daddr[W-1:0];
        bus.D_MEM_ADDR_MODE = mode[0];
    endtask

    // Issued on a falling edge; every following falling edge is checked against the fixed timing.
    task automatic do_cmd(input int op, input int bsel, input int imm, input int sel,
                          input int daddr, input int mode);
        int acc_before;
        acc_before = m_acc;
        drive(op, bsel, imm, sel, daddr, mode);
        bus.START = 1'b1;
        @(negedge CLK);
        bus.START = 1'b0;
        chk_val("busy_read", bus.BUSY, 1);
        chk_val("done_read", bus.DONE, 0);
        @(negedge CLK);
        chk_val("done_exec", bus.DONE, 1);
        chk_val("acc_stable", bus.ACC_OUT, acc_before);
        model_exec(op, bsel, imm, sel, daddr, mode);
        @(negedge CLK);
        chk_val("done_clear", bus.DONE, 0);
        chk_val("busy_clear", bus.BUSY, 0);
        chk_val("acc", bus.ACC_OUT, m_acc);
        chk_val("flag_c", bus.FLAG_C, m_c);
        chk_val("flag_z", bus.FLAG_Z, m_z);
    endtask

    initial begin
        int dones;
        bus.START = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        model_reset();
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 0;

        RST = 1'b1;
        repeat (2) @(negedge CLK);
        chk_val("rst_acc", bus.ACC_OUT, 0);
        chk_val("rst_c", bus.FLAG_C, 0);
        chk_val("rst_z", bus.FLAG_Z, 0);
        chk_val("rst_busy", bus.BUSY, 0);
        chk_val("rst_done", bus.DONE, 0);

        // START held through reset must not launch a command.
        drive(OP_LD, 0, 8'h33, 0, 0, 0);
        bus.START = 1'b1;
        repeat (3) begin
            @(negedge CLK);
            chk_val("rst_start_done", bus.DONE, 0);
            chk_val("rst_start_busy", bus.BUSY, 0);
        end
        bus.START = 1'b0;
        RST = 1'b0;
        @(negedge CLK);
        chk_val("post_rst_busy", bus.BUSY, 0);

        for (int i = 0; i < DEPTH; i++) begin
            do_cmd(OP_LD, 0, $urandom_range(0, M - 1), 0, 0, 0);
            do_cmd(OP_STM, 0, 0, 0, i, 0);
        end

        do_cmd(OP_LD, 0, 8'h05, 0, 0, 0);
        do_cmd(OP_ADD, 0, 8'hFF, 0, 0, 0);
        chk_val("tp_add_acc", bus.ACC_OUT, 8'h04);
        chk_val("tp_add_c", bus.FLAG_C, 1);
        chk_val("tp_add_z", bus.FLAG_Z, 0);
        do_cmd(OP_ADC, 0, 8'h00, 0, 0, 0);
        chk_val("tp_adc_acc", bus.ACC_OUT, 8'h05);
        chk_val("tp_adc_c", bus.FLAG_C, 0);
        do_cmd(OP_SUB, 0, 8'h05, 0, 0, 0);
        chk_val("tp_sub_acc", bus.ACC_OUT, 8'h00);
        chk_val("tp_sub_z", bus.FLAG_Z, 1);
        chk_val("tp_sub_c", bus.FLAG_C, 0);
        do_cmd(OP_CMP, 0, 8'h06, 0, 0, 0);
        chk_val("tp_cmp_acc", bus.ACC_OUT, 8'h00);
        chk_val("tp_cmp_c", bus.FLAG_C, 1);
        chk_val("tp_cmp_z", bus.FLAG_Z, 0);

        do_cmd(OP_LD, 0, 8'hA5, 0, 0, 0);
        do_cmd(OP_STR, 0, 0, 3, 0, 0);
        do_cmd(OP_LD, 0, 8'h10, 0, 0, 0);
        do_cmd(OP_STR, 0, 0, 2, 0, 0);
        do_cmd(OP_LD, 0, 8'hA5, 0, 0, 0);
        do_cmd(OP_STM, 0, 0, 2, 0, 1);
        do_cmd(OP_LD, 0, 8'h00, 0, 0, 0);
        do_cmd(OP_LD, 2, 0, 0, 8'h10, 0);
        chk_val("tp_ind_mem", bus.ACC_OUT, 8'hA5);
        do_cmd(OP_LD, 0, 8'h00, 0, 0, 0);
        do_cmd(OP_LD, 1, 0, 3, 0, 0);
        chk_val("tp_reg_rd", bus.ACC_OUT, 8'hA5);

        do_cmd(OP_LD, 0, 8'h3C, 0, 0, 0);
        do_cmd(OP_STM, 0, 0, 0, 8'h13, 0);
        do_cmd(OP_LD, 0, 8'h00, 0, 0, 0);
        do_cmd(OP_LD, 2, 0, 0, 8'h03, 0);
        chk_val("tp_wrap", bus.ACC_OUT, 8'h3C);

        // A second START during READ is dropped: one DONE, first command's result only.
        drive(OP_LD, 0, 8'h11, 0, 0, 0);
        bus.START = 1'b1;
        @(negedge CLK);
        drive(OP_ADD, 0, 8'h22, 0, 0, 0);
        bus.START = 1'b1;
        @(negedge CLK);
        bus.START = 1'b0;
        chk_val("ign_done", bus.DONE, 1);
        model_exec(OP_LD, 0, 8'h11, 0, 0, 0);
        dones = 0;
        repeat (4) begin
            @(negedge CLK);
            if (bus.DONE) dones++;
        end
        chk_val("ign_extra_done", dones, 0);
        chk_val("ign_acc", bus.ACC_OUT, 8'h11);
        chk_val("ign_busy", bus.BUSY, 0);

        // Reset during READ of an STR.
        do_cmd(OP_LD, 0, 8'h77, 0, 0, 0);
        drive(OP_STR, 0, 0, 5, 0, 0);
        bus.START = 1'b1;
        @(negedge CLK);
        bus.START = 1'b0;
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        model_reset();
        chk_val("abort_busy", bus.BUSY, 0);
        chk_val("abort_done", bus.DONE, 0);
        chk_val("abort_acc", bus.ACC_OUT, 0);
        do_cmd(OP_LD, 1, 0, 5, 0, 0);
        chk_val("abort_reg", bus.ACC_OUT, 0);

        // Reset landing on the EXEC edge of an STM leaves memory untouched.
        do_cmd(OP_LD, 0, (m_mem[7] + 1) % M, 0, 0, 0);
        drive(OP_STM, 0, 0, 0, 7, 0);
        bus.START = 1'b1;
        @(negedge CLK);
        bus.START = 1'b0;
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        model_reset();
        chk_val("abort_stm_busy", bus.BUSY, 0);
        do_cmd(OP_LD, 2, 0, 0, 7, 0);

        for (int n = 0; n < 400; n++) begin
            do_cmd($urandom_range(0, 15), $urandom_range(0, 3), $urandom_range(0, M - 1),
                   $urandom_range(0, NREG - 1), $urandom_range(0, M - 1), $urandom_range(0, 1));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
